multi_alarm_timekeeper: RTL

- Parametrised BCD time-of-day core with NUM_ALARMS independent alarm slots, a snooze/dismiss ring state machine and an automatic ring timeout.
- Supersedes the fixed single-alarm timer datapath: seconds, minutes and hours counters, direct field load, per-slot alarm compare.
- Advances on an external 1 Hz enable pulse from the existing clock divider.
- Outputs feed the 7-segment scanner (packed BCD) and the beeper (ring).

---
 rtl/timekeeper_pkg.sv | 40 ++++
 rtl/bcd2_counter.sv | 41 ++++
 rtl/multi_alarm_timekeeper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/timekeeper_pkg.sv
// Shared types, field codes and BCD helpers for the multi-alarm timekeeper.
package timekeeper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ring_state_t;

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Packed BCD bytes with legal digits order the same as their decimal values.
    function automatic logic bcd_valid(input logic [7:0] value,
                                       input logic [3:0] max_tens,
                                       input logic [7:0] max_value);
        return (value[3:0] <= 4'd9) && (value[7:4] <= max_tens) && (value <= max_value);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] r;
        if (value[3:0] == 4'd9) begin
            r[7:4] = value[7:4] + 4'd1;
            r[3:0] = 4'd0;
        end else begin
            r[7:4] = value[7:4];
            r[3:0] = value[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed BCD counter wrapping MAX -> 00, with load priority over increment.
module bcd2_counter
    import timekeeper_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] value,
    output logic [7:0] value_d,
    output logic       carry
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    logic [7:0] value_q;

    always_comb begin
        carry   = inc && !load && (value_q == MAX_BCD);
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (inc) begin
            value_d = carry ? '0 : bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// BCD time-of-day core with NUM_ALARMS alarm slots and a ring/snooze/timeout state machine.
module multi_alarm_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned HOUR_MAX   = 23,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SECS  = 60,
    localparam int unsigned IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1hz,
    input  logic          set_time_we,
    input  logic [1:0]    set_field,
    input  logic [7:0]    set_value,
    input  logic          alarm_we,
    input  logic [IW-1:0] alarm_idx,
    input  logic [7:0]    alarm_hour,
    input  logic [7:0]    alarm_min,
    input  logic          alarm_on,
    input  logic          snooze,
    input  logic          dismiss,
    output logic [7:0]    sec_bcd,
    output logic [7:0]    min_bcd,
    output logic [7:0]    hour_bcd,
    output logic          ring,
    output logic [IW-1:0] ring_idx,
    output logic          snoozed,
    output logic          wr_err
);

    localparam logic [7:0]  HOUR_BCD    = to_bcd(HOUR_MAX);
    localparam logic [11:0] RING_LOAD   = 12'(RING_SECS);
    localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

    logic        time_ok, time_err, alarm_ok, alarm_err, tick_app;
    logic        load_sec, load_min, load_hour;
    logic        sec_carry, min_carry, hour_carry;
    logic [7:0]  sec_next, min_next, hour_next;
    logic [31:0] idx_ext;

    logic [7:0]            alarm_hour_q [NUM_ALARMS];
    logic [7:0]            alarm_hour_d [NUM_ALARMS];
    logic [7:0]            alarm_min_q  [NUM_ALARMS];
    logic [7:0]            alarm_min_d  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_on_q, alarm_on_d;

    ring_state_t state_q, state_d;
    logic [IW-1:0] ring_idx_q, ring_idx_d;
    logic [11:0]   cnt_q, cnt_d;
    logic          wr_err_q, wr_err_d;
    logic          match;
    logic [IW-1:0] match_idx;

    always_comb begin
        case (set_field)
            FIELD_SEC:  time_ok = bcd_valid(set_value, 4'd5, 8'h59);
            FIELD_MIN:  time_ok = bcd_valid(set_value, 4'd5, 8'h59);
            FIELD_HOUR: time_ok = bcd_valid(set_value, 4'd9, HOUR_BCD);
            default:    time_ok = 1'b0;
        endcase
        time_err  = set_time_we && !time_ok;
        load_sec  = set_time_we && time_ok && (set_field == FIELD_SEC);
        load_min  = set_time_we && time_ok && (set_field == FIELD_MIN);
        load_hour = set_time_we && time_ok && (set_field == FIELD_HOUR);
        // Any time write in a tick cycle swallows the whole tick.
        tick_app  = tick_1hz && !set_time_we;

        idx_ext   = 32'(alarm_idx);
        alarm_ok  = (idx_ext < NUM_ALARMS) && bcd_valid(alarm_hour, 4'd9, HOUR_BCD)
                    && bcd_valid(alarm_min, 4'd5, 8'h59);
        alarm_err = alarm_we && !alarm_ok;
        wr_err_d  = time_err || alarm_err;
    end

    bcd2_counter #(.MAX(59)) u_sec (
        .clk(clk), .rst(rst), .inc(tick_app), .load(load_sec), .load_value(set_value),
        .value(sec_bcd), .value_d(sec_next), .carry(sec_carry)
    );

    bcd2_counter #(.MAX(59)) u_min (
        .clk(clk), .rst(rst), .inc(sec_carry), .load(load_min), .load_value(set_value),
        .value(min_bcd), .value_d(min_next), .carry(min_carry)
    );

    bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .inc(min_carry), .load(load_hour), .load_value(set_value),
        .value(hour_bcd), .value_d(hour_next), .carry(hour_carry)
    );

    always_comb begin
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_on_d   = alarm_on_q;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_we && alarm_ok && (idx_ext == i)) begin
                alarm_hour_d[i] = alarm_hour;
                alarm_min_d[i]  = alarm_min;
                alarm_on_d[i]   = alarm_on;
            end
        end
    end

    // Match is judged against the post-tick time so ring lines up with hh:mm:00.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (!match && alarm_on_q[i] && (alarm_hour_q[i] == hour_next)
                && (alarm_min_q[i] == min_next)) begin
                match     = 1'b1;
                match_idx = IW'(i);
            end
        end
        match = match && tick_app && (sec_next == 8'h00);
    end

    always_comb begin
        state_d    = state_q;
        ring_idx_d = ring_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (match) begin
                    state_d    = RINGING;
                    ring_idx_d = match_idx;
                    cnt_d      = RING_LOAD;
                end
            end
            RINGING: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZED;
                    cnt_d   = SNOOZE_LOAD;
                end else if (tick_app) begin
                    if (cnt_q <= 12'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 12'd1;
                    end
                end
            end
            SNOOZED: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d    = RINGING;
                    ring_idx_d = match_idx;
                    cnt_d      = RING_LOAD;
                end else if (tick_app) begin
                    if (cnt_q <= 12'd1) begin
                        state_d = RINGING;
                        cnt_d   = RING_LOAD;
                    end else begin
                        cnt_d = cnt_q - 12'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ring_idx_q <= '0;
            cnt_q      <= '0;
            wr_err_q   <= 1'b0;
            alarm_on_q <= '0;
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                alarm_hour_q[i] <= '0;
                alarm_min_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            ring_idx_q   <= ring_idx_d;
            cnt_q        <= cnt_d;
            wr_err_q     <= wr_err_d;
            alarm_on_q   <= alarm_on_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
        end
    end

    assign ring     = (state_q == RINGING);
    assign snoozed  = (state_q == SNOOZED);
    assign ring_idx = ring_idx_q;
    assign wr_err   = wr_err_q;

    logic unused_hour_carry;
    assign unused_hour_carry = hour_carry;

endmodule
